amiga_clk_phase_gen: RTL and testbench

Parametrised successor to the chipset clock generator. It divides the 28 MHz enable stream into NPH equally spaced phase clocks of period DIV enables (C1..C4 / CCK / CCKQ at the defaults), plus a double-rate clock and its quadrature (C7M / CDAC). Each clock comes with one-cycle rise and fall strobes. The block adds run/stop gating and a deferred resynchronisation request. It sits between the oscillator enable and every chip model or testbench that consumes CCK-domain strobes.

---
 rtl/amiga_clk_phase_gen.sv | 122 ++++++++++++
 tb/tb_amiga_clk_phase_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/amiga_clk_phase_gen.sv
// Chipset clock phase generator: NPH phase clocks of period DIV enables plus
// a double-rate clock pair (c7m/cdac), each with one-cycle rise/fall strobes.

module amiga_clk_phase_lane #(
  parameter bit RST_LVL = 1'b0
) (
  input  logic main_clk,
  input  logic main_rst_n,
  input  logic ena,
  input  logic lvl_nxt,
  output logic lvl,
  output logic rise,
  output logic fall
);
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      lvl  <= RST_LVL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else if (ena) begin
      lvl  <= lvl_nxt;
      rise <= lvl_nxt & ~lvl;
      fall <= ~lvl_nxt & lvl;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end
endmodule

module amiga_clk_phase_gen #(
  parameter int DIV = 8,
  parameter int NPH = 4,
  parameter int CW  = $clog2(DIV)
) (
  input  logic           main_clk,
  input  logic           main_rst_n,
  input  logic           ena_28m,
  input  logic           run,
  input  logic           sync,
  output logic [CW-1:0]  cnt,
  output logic [NPH-1:0] ph_lvl,
  output logic [NPH-1:0] ph_rise,
  output logic [NPH-1:0] ph_fall,
  output logic [2:0]     c7m,
  output logic [2:0]     cdac
);
  localparam int STEP  = DIV / NPH;
  localparam int LANES = NPH + 2;

  // Lanes 0..NPH-1 are the phase clocks, lane NPH is c7m, lane NPH+1 is cdac.
  function automatic logic lvl_at(input int n, input int g);
    int d;
    if (g < NPH) begin
      d = n - g * STEP;
      if (d < 0) d = d + DIV;
      return d < DIV / 2;
    end else if (g == NPH) begin
      return (n % (DIV / 2)) < DIV / 4;
    end else begin
      d = n - DIV / 8;
      if (d < 0) d = d + DIV / 2;
      return (d % (DIV / 2)) < DIV / 4;
    end
  endfunction

  logic          sync_pend, held, held_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [LANES-1:0] lvl_nxt, lvl, rise, fall;

  always_comb begin
    cnt_nxt  = cnt;
    held_nxt = held;
    if (sync_pend || sync) begin
      cnt_nxt  = '0;
      held_nxt = 1'b0;
    end else if (held && !run) begin
      cnt_nxt  = '0;
    end else begin
      cnt_nxt  = (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
      // A stop request lands on the wrap: the period is completed first.
      held_nxt = (cnt == CW'(DIV - 1)) && !run;
    end
  end

  always_comb begin
    lvl_nxt = '0;
    for (int g = 0; g < LANES; g++) lvl_nxt[g] = lvl_at(int'(cnt_nxt), g);
  end

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      cnt       <= '0;
      sync_pend <= 1'b0;
      held      <= 1'b0;
    end else if (ena_28m) begin
      cnt       <= cnt_nxt;
      held      <= held_nxt;
      sync_pend <= 1'b0;
    end else begin
      sync_pend <= sync_pend | sync;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    amiga_clk_phase_lane #(.RST_LVL(lvl_at(0, g))) u_lane (
      .main_clk   (main_clk),
      .main_rst_n (main_rst_n),
      .ena        (ena_28m),
      .lvl_nxt    (lvl_nxt[g]),
      .lvl        (lvl[g]),
      .rise       (rise[g]),
      .fall       (fall[g])
    );
  end

  assign ph_lvl  = lvl[NPH-1:0];
  assign ph_rise = rise[NPH-1:0];
  assign ph_fall = fall[NPH-1:0];
  assign c7m     = {fall[NPH], rise[NPH], lvl[NPH]};
  assign cdac    = {fall[NPH+1], rise[NPH+1], lvl[NPH+1]};
endmodule

// File: tb/tb_amiga_clk_phase_gen.sv
// Bench for amiga_clk_phase_gen: default instance plus DIV=16/NPH=2 instance,
// a per-cycle behavioural model, and directed literal checks.

module tb_amiga_clk_phase_gen;
  logic main_clk = 1'b0, main_rst_n = 1'b1, ena_28m = 1'b0, run = 1'b1, sync = 1'b0;
  always #5 main_clk = ~main_clk;

  logic [2:0] cnt_a;  logic [3:0] ph_lvl_a, ph_rise_a, ph_fall_a;  logic [2:0] c7m_a, cdac_a;
  logic [3:0] cnt_b;  logic [1:0] ph_lvl_b, ph_rise_b, ph_fall_b;  logic [2:0] c7m_b, cdac_b;

  amiga_clk_phase_gen #(.DIV(8), .NPH(4)) dut_a (
    .main_clk(main_clk), .main_rst_n(main_rst_n), .ena_28m(ena_28m), .run(run), .sync(sync),
    .cnt(cnt_a), .ph_lvl(ph_lvl_a), .ph_rise(ph_rise_a), .ph_fall(ph_fall_a),
    .c7m(c7m_a), .cdac(cdac_a));

  amiga_clk_phase_gen #(.DIV(16), .NPH(2)) dut_b (
    .main_clk(main_clk), .main_rst_n(main_rst_n), .ena_28m(ena_28m), .run(run), .sync(sync),
    .cnt(cnt_b), .ph_lvl(ph_lvl_b), .ph_rise(ph_rise_b), .ph_fall(ph_fall_b),
    .c7m(c7m_b), .cdac(cdac_b));

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Level vector for count n: [nph-1:0] phases, [4] c7m, [5] cdac.
  // Each clock is a half-duty square wave starting at its own offset.
  function automatic bit [5:0] levels(input int n, input int div, input int nph);
    bit [5:0] v = '0;
    for (int k = 0; k < nph; k++) v[k] = ((n - k * (div / nph) + div) % div) < div / 2;
    v[4] = (n % (div / 2)) < div / 4;
    v[5] = ((n + div / 2 - div / 8) % (div / 2)) < div / 4;
    return v;
  endfunction

  int       m_cnt [2];
  bit       m_pend[2], m_held[2];
  bit [5:0] m_lv[2], m_ri[2], m_fa[2];

  always @(posedge main_clk or negedge main_rst_n) begin
    int dv, np, nx;
    bit hd;
    bit [5:0] nl;
    for (int i = 0; i < 2; i++) begin
      dv = (i == 0) ? 8 : 16;
      np = (i == 0) ? 4 : 2;
      if (!main_rst_n) begin
        m_cnt[i] <= 0; m_pend[i] <= 1'b0; m_held[i] <= 1'b0;
        m_lv[i] <= levels(0, dv, np); m_ri[i] <= '0; m_fa[i] <= '0;
      end else if (ena_28m) begin
        if (m_pend[i] || sync) begin
          nx = 0; hd = 1'b0;
        end else if (m_held[i] && !run) begin
          nx = 0; hd = 1'b1;
        end else begin
          nx = (m_cnt[i] + 1) % dv; hd = (nx == 0) && !run;
        end
        nl = levels(nx, dv, np);
        m_cnt[i] <= nx; m_held[i] <= hd; m_pend[i] <= 1'b0;
        m_ri[i] <= nl & ~m_lv[i]; m_fa[i] <= ~nl & m_lv[i]; m_lv[i] <= nl;
      end else begin
        m_pend[i] <= m_pend[i] | sync;
        m_ri[i] <= '0; m_fa[i] <= '0;
      end
    end
  end

  always @(negedge main_clk) if (chk_en) begin
    check("m_cnt_a",  32'(cnt_a), 32'(m_cnt[0]));
    check("m_lvl_a",  {cdac_a[0], c7m_a[0], ph_lvl_a},  m_lv[0]);
    check("m_rise_a", {cdac_a[1], c7m_a[1], ph_rise_a}, m_ri[0]);
    check("m_fall_a", {cdac_a[2], c7m_a[2], ph_fall_a}, m_fa[0]);
    check("overlap_a", ph_rise_a & ph_fall_a, 0);
    check("m_cnt_b",  32'(cnt_b), 32'(m_cnt[1]));
    check("m_lvl_b",  {cdac_b[0], c7m_b[0], 2'b00, ph_lvl_b},  m_lv[1]);
    check("m_rise_b", {cdac_b[1], c7m_b[1], 2'b00, ph_rise_b}, m_ri[1]);
    check("m_fall_b", {cdac_b[2], c7m_b[2], 2'b00, ph_fall_b}, m_fa[1]);
  end

  task automatic step();
    @(posedge main_clk);
    @(negedge main_clk);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_cnt"},  cnt_a, 0);
    check({nm, "_lvl"},  ph_lvl_a, 4'b1001);
    check({nm, "_str"},  {ph_rise_a, ph_fall_a}, 0);
    check({nm, "_c7m"},  c7m_a, 3'b001);
    check({nm, "_cdac"}, cdac_a, 3'b000);
    check({nm, "_lvl_b"}, {cdac_b, c7m_b, ph_lvl_b}, {3'b000, 3'b001, 2'b01});
  endtask

  initial begin
    #2 main_rst_n = 1'b0;
    #1 check_reset_vals("reset");
    chk_en = 1'b1;
    @(negedge main_clk);
    main_rst_n = 1'b1; ena_28m = 1'b1; run = 1'b1;

    // Free-running, one enable per clock.
    for (int e = 1; e <= 16; e++) begin
      step();
      check("cnt_free", cnt_a, e % 8);
      check("ph0_rise_every8", ph_rise_a[0], e % 8 == 0);
      check("ph1_rise_cnt2", ph_rise_a[1], e % 8 == 2);
      check("c7m_rise_0_4", c7m_a[1], e % 4 == 0);
      check("cdac_rise_1_5", cdac_a[1], e % 4 == 1);
      check("b_ph1_rise_cnt8", ph_rise_b[1], e % 16 == 8);
      check("b_c7m_rise_per8", c7m_b[1], e % 8 == 0);
      check("b_cdac_rise_lag2", cdac_b[1], e % 8 == 2);
    end

    // One enable in four.
    for (int i = 0; i < 16; i++) begin
      ena_28m = (i % 4 == 3);
      step();
      check("cnt_gated", cnt_a, ((i + 1) / 4) % 8);
      if (i % 4 != 3)
        check("no_strobe_gated", {ph_rise_a, ph_fall_a, c7m_a[2:1], cdac_a[2:1]}, 0);
    end
    ena_28m = 1'b1;

    // Stop request at cnt=3.
    for (int g = 0; g < 16 && cnt_a != 3'd3; g++) step();
    check("reach_cnt3", cnt_a, 3);
    run = 1'b0;
    for (int j = 4; j <= 7; j++) begin
      step();
      check("stop_completes", cnt_a, j);
    end
    step();
    check("stop_wrap_cnt", cnt_a, 0);
    check("stop_wrap_rise", ph_rise_a[0], 1);
    for (int j = 0; j < 3; j++) begin
      step();
      check("held_cnt", cnt_a, 0);
      check("held_no_strobe", {ph_rise_a, ph_fall_a, c7m_a[2:1], cdac_a[2:1]}, 0);
    end
    run = 1'b1;
    step();
    check("restart_cnt1", cnt_a, 1);

    // Resync requested on a non-enabled edge at cnt=5.
    for (int g = 0; g < 16 && cnt_a != 3'd5; g++) step();
    check("reach_cnt5", cnt_a, 5);
    ena_28m = 1'b0; sync = 1'b1;
    step();
    check("sync_deferred", cnt_a, 5);
    sync = 1'b0;
    step();
    check("sync_still5", cnt_a, 5);
    ena_28m = 1'b1;
    step();
    check("sync_cnt0", cnt_a, 0);
    check("sync_rise0", ph_rise_a[0], 1);
    check("sync_fall3", ph_fall_a[3], 0);
    check("sync_rise3", ph_rise_a[3], 1);
    check("sync_lvl", ph_lvl_a, 4'b1001);

    // Resync while held with run still low.
    run = 1'b0;
    for (int g = 0; g < 16; g++) begin
      step();
      if (cnt_a == 3'd0) break;
    end
    check("reach_wrap", cnt_a, 0);
    step();
    sync = 1'b1;
    step();
    check("held_sync_cnt", cnt_a, 0);
    check("held_sync_quiet", {ph_rise_a, ph_fall_a, c7m_a[2:1], cdac_a[2:1]}, 0);
    sync = 1'b0;
    step();
    check("held_cleared_adv", cnt_a, 1);
    run = 1'b1;

    // Asynchronous reset mid-period with strobes active.
    for (int g = 0; g < 16 && cnt_a != 3'd6; g++) step();
    check("reach_cnt6", cnt_a, 6);
    check("strobe_active6", ph_rise_a[3], 1);
    #2 main_rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge main_clk);
    main_rst_n = 1'b1;

    // Reset must also drop a pending resync.
    for (int g = 0; g < 16 && cnt_a != 3'd6; g++) step();
    check("reach_cnt6b", cnt_a, 6);
    ena_28m = 1'b0; sync = 1'b1;
    step();
    sync = 1'b0;
    #2 main_rst_n = 1'b0;
    @(negedge main_clk);
    main_rst_n = 1'b1; ena_28m = 1'b1;
    step();
    check("pend_cleared", cnt_a, 1);

    ena_28m = 1'b0;
    step();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
